// File: rtl/lsu_dmem_master.sv
// Load/store data-memory master.
// Takes one byte/half/word/dword request at a time and issues one or two
// aligned 64-bit beats on the dmem port. Load data is shifted down to bit 0
// and extended. Every request, including stores, gets a completion response.
//
// state | meaning
// IDLE  | ready for a request, dmem idle
// BEAT0 | first (or only) aligned beat on dmem
// BEAT1 | second beat of an access that crosses an 8-byte boundary
// RESP  | completion held until the consumer takes it
module lsu_dmem_master #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_en,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [63:0] dmem_wmask,
  output logic        dmem_wen,
  input  logic [63:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t      state;
  state_t      state_nxt;

  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] lo_buf;
  logic [63:0] hi_buf;
  logic        wen_q;
  logic        signed_q;
  logic        err_q;
  logic [1:0]  size_q;

  logic [2:0]  off;
  logic [3:0]  req_end;
  logic [3:0]  lat_end;
  logic        req_cross;
  logic        lat_cross;
  logic [7:0]  byte_mask;
  logic [63:0] raw;
  logic [63:0] ext;

  // One past the last byte touched, counted from the start of the first beat.
  assign req_end   = {1'b0, req_addr[2:0]} + (4'd1 << req_size);
  assign req_cross = req_end > 4'd8;
  assign off       = addr_q[2:0];
  assign lat_end   = {1'b0, off} + (4'd1 << size_q);
  assign lat_cross = lat_end > 4'd8;

  // No request is taken while reset is asserted.
  assign req_ready = (state == IDLE) && !rst;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and dmem beat outputs, decoded from registered state only.
  always_comb begin
    state_nxt  = state;
    dmem_en    = 1'b0;
    dmem_wen   = 1'b0;
    dmem_addr  = 64'd0;
    dmem_wdata = 64'd0;
    byte_mask  = 8'd0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = (req_cross && !MISALIGN_EN) ? RESP : BEAT0;
      end
      BEAT0: begin
        dmem_en    = 1'b1;
        dmem_wen   = wen_q;
        dmem_addr  = {addr_q[63:3], 3'b000};
        dmem_wdata = wdata_q << {off, 3'b000};
        for (int i = 0; i < 8; i++)
          byte_mask[i] = (4'(i) >= {1'b0, off}) && (4'(i) < lat_end);
        state_nxt  = lat_cross ? BEAT1 : RESP;
      end
      BEAT1: begin
        dmem_en    = 1'b1;
        dmem_wen   = wen_q;
        dmem_addr  = {addr_q[63:3], 3'b000} + 64'd8;
        dmem_wdata = wdata_q >> (7'd64 - {1'b0, off, 3'b000});
        for (int i = 0; i < 8; i++)
          byte_mask[i] = (4'(i) + 4'd8) < lat_end;
        state_nxt  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Expand byte lanes into the bit mask; the mask is silent on reads.
  always_comb begin
    dmem_wmask = 64'd0;
    for (int i = 0; i < 8; i++)
      dmem_wmask[8*i +: 8] = {8{byte_mask[i] & dmem_wen}};
  end

  // Request latch and read-beat capture; hi_buf clears so unsplit loads see zeros above lane 7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      wen_q    <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'd0;
      err_q    <= 1'b0;
      lo_buf   <= 64'd0;
      hi_buf   <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wen_q    <= req_wen;
            signed_q <= req_signed;
            size_q   <= req_size;
            err_q    <= req_cross && !MISALIGN_EN;
            lo_buf   <= 64'd0;
            hi_buf   <= 64'd0;
          end
        end
        BEAT0:   lo_buf <= dmem_rdata;
        BEAT1:   hi_buf <= dmem_rdata;
        default: ;
      endcase
    end
  end

  // Align the two captured beats down to bit 0 and extend to the access size.
  always_comb begin
    raw = 64'({hi_buf, lo_buf} >> {off, 3'b000});
    ext = raw;
    case (size_q)
      2'd0:    ext = signed_q ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
      2'd1:    ext = signed_q ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
      2'd2:    ext = signed_q ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
      default: ext = raw;
    endcase
  end

  assign resp_rdata = (state == RESP && !wen_q && !err_q) ? ext : 64'd0;
  assign resp_err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master: a vector table of single requests
// against a small RAM model, plus sequences for backpressure, the refused
// boundary-crossing case and reset in the middle of a split store.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = 64'd0;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        dmem_en;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_wmask;
  logic        dmem_wen;
  logic [63:0] dmem_rdata;

  logic        req_valid_nm = 1'b0;
  logic        req_ready_nm;
  logic        resp_valid_nm;
  logic        resp_ready_nm = 1'b0;
  logic [63:0] resp_rdata_nm;
  logic        resp_err_nm;
  logic        dmem_en_nm;
  logic [63:0] dmem_addr_nm;
  logic [63:0] dmem_wdata_nm;
  logic [63:0] dmem_wmask_nm;
  logic        dmem_wen_nm;
  logic [63:0] dmem_rdata_nm = 64'h0000_0000_0000_00A5;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu_dmem_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_wen(dmem_wen), .dmem_rdata(dmem_rdata)
  );

  lsu_dmem_master #(.MISALIGN_EN(1'b0)) dut_nm (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_nm), .req_ready(req_ready_nm), .req_addr(req_addr),
    .req_wen(req_wen), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid_nm), .resp_ready(resp_ready_nm),
    .resp_rdata(resp_rdata_nm), .resp_err(resp_err_nm),
    .dmem_en(dmem_en_nm), .dmem_addr(dmem_addr_nm), .dmem_wdata(dmem_wdata_nm),
    .dmem_wmask(dmem_wmask_nm), .dmem_wen(dmem_wen_nm), .dmem_rdata(dmem_rdata_nm)
  );

  // RAM model: dwords at 0x8000_0000 + 8*k, combinational read, masked write.
  logic [63:0] mem [0:15] = '{
    64'h3400_0000_0000_0000, 64'h0000_0000_0000_0092,
    64'h0000_0000_8000_0000, 64'hFEDC_BA98_7654_3210,
    64'h0000_0000_0000_0000, 64'hDEAD_BEEF_DEAD_BEEF,
    64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0
  };

  assign dmem_rdata = mem[dmem_addr[6:3]];

  always @(posedge clk) begin
    if (dmem_en && dmem_wen)
      mem[dmem_addr[6:3]] <= (mem[dmem_addr[6:3]] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
  end

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          lat;
    logic [63:0] a0, m0, d0;
    logic [63:0] a1, m1, d1;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic offer(input logic [63:0] a, input logic w, input logic [1:0] s,
                       input logic sg, input logic [63:0] wd);
    int k;
    @(negedge clk);
    req_addr = a; req_wen = w; req_size = s; req_signed = sg; req_wdata = wd;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_offer", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic collect(output int lat, output logic w0,
                         output logic [63:0] a0, output logic [63:0] m0, output logic [63:0] d0,
                         output logic [63:0] a1, output logic [63:0] m1, output logic [63:0] d1);
    bit done;
    lat = 0; w0 = 1'b0; a0 = '0; m0 = '0; d0 = '0; a1 = '0; m1 = '0; d1 = '0;
    done = 1'b0;
    for (int c = 1; c <= 10 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a0 = dmem_addr; m0 = dmem_wmask; d0 = dmem_wdata; w0 = dmem_wen;
      end else if (c == 2 && !resp_valid) begin
        a1 = dmem_addr; m1 = dmem_wmask; d1 = dmem_wdata;
      end
      if (resp_valid) begin
        lat = c;
        done = 1'b1;
      end
    end
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic w0;
    logic [63:0] a0, m0, d0, a1, m1, d1, held;

    //       addr                   wen   sz    sgn   wdata                  rdata                  lat a0                     m0                     d0                     a1                     m1                     d1
    vecs[0]  = '{64'h8000_0013, 1'b0, 2'd0, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 2, 64'h8000_0010, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    vecs[1]  = '{64'h8000_0013, 1'b0, 2'd0, 1'b0, 64'd0, 64'h0000_0000_0000_0080, 2, 64'h8000_0010, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    vecs[2]  = '{64'h8000_0007, 1'b0, 2'd1, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_9234, 3, 64'h8000_0000, 64'd0, 64'd0, 64'h8000_0008, 64'd0, 64'd0};
    vecs[3]  = '{64'h8000_0007, 1'b0, 2'd1, 1'b0, 64'd0, 64'h0000_0000_0000_9234, 3, 64'h8000_0000, 64'd0, 64'd0, 64'h8000_0008, 64'd0, 64'd0};
    vecs[4]  = '{64'h8000_0018, 1'b0, 2'd3, 1'b1, 64'd0, 64'hFEDC_BA98_7654_3210, 2, 64'h8000_0018, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    vecs[5]  = '{64'h8000_001C, 1'b0, 2'd2, 1'b1, 64'd0, 64'hFFFF_FFFF_FEDC_BA98, 2, 64'h8000_0018, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    vecs[6]  = '{64'h8000_001E, 1'b0, 2'd1, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FEDC, 2, 64'h8000_0018, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    vecs[7]  = '{64'h8000_001D, 1'b0, 2'd3, 1'b0, 64'd0, 64'h0000_0000_00FE_DCBA, 3, 64'h8000_0018, 64'd0, 64'd0, 64'h8000_0020, 64'd0, 64'd0};
    vecs[8]  = '{64'h8000_0010, 1'b1, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'd0, 2, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1122_3344_5566_7788, 64'd0, 64'd0, 64'd0};
    vecs[9]  = '{64'h8000_0006, 1'b1, 2'd2, 1'b0, 64'h0000_0000_AABB_CCDD, 64'd0, 3, 64'h8000_0000, 64'hFFFF_0000_0000_0000, 64'hCCDD_0000_0000_0000, 64'h8000_0008, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_AABB};
    vecs[10] = '{64'h8000_0010, 1'b0, 2'd3, 1'b0, 64'd0, 64'h1122_3344_5566_7788, 2, 64'h8000_0010, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    vecs[11] = '{64'h8000_0007, 1'b0, 2'd1, 1'b0, 64'd0, 64'h0000_0000_0000_BBCC, 3, 64'h8000_0000, 64'd0, 64'd0, 64'h8000_0008, 64'd0, 64'd0};

    // Reset state.
    #3;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_dmem_en", {63'd0, dmem_en}, 64'd0);
    chk("rst_dmem_wen", {63'd0, dmem_wen}, 64'd0);
    chk("rst_dmem_addr", dmem_addr, 64'd0);
    chk("rst_dmem_wdata", dmem_wdata, 64'd0);
    chk("rst_dmem_wmask", dmem_wmask, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Vector table.
    for (int v = 0; v < 12; v++) begin
      offer(vecs[v].addr, vecs[v].wen, vecs[v].size, vecs[v].sgn, vecs[v].wdata);
      collect(lat, w0, a0, m0, d0, a1, m1, d1);
      chk($sformatf("v%0d_lat", v), 64'(lat), 64'(vecs[v].lat));
      chk($sformatf("v%0d_rdata", v), resp_rdata, vecs[v].rdata);
      chk($sformatf("v%0d_err", v), {63'd0, resp_err}, 64'd0);
      chk($sformatf("v%0d_wen0", v), {63'd0, w0}, {63'd0, vecs[v].wen});
      chk($sformatf("v%0d_addr0", v), a0, vecs[v].a0);
      chk($sformatf("v%0d_mask0", v), m0, vecs[v].m0);
      chk($sformatf("v%0d_wdata0", v), d0, vecs[v].d0);
      if (vecs[v].lat == 3) begin
        chk($sformatf("v%0d_addr1", v), a1, vecs[v].a1);
        chk($sformatf("v%0d_mask1", v), m1, vecs[v].m1);
        chk($sformatf("v%0d_wdata1", v), d1, vecs[v].d1);
      end
      release_resp();
    end
    chk("mem0_after_split_store", mem[0], 64'hCCDD_0000_0000_0000);
    chk("mem1_after_split_store", mem[1], 64'h0000_0000_0000_AABB);
    chk("mem2_after_dword_store", mem[2], 64'h1122_3344_5566_7788);

    // Backpressure: completion held 5 cycles while a new request waits.
    offer(64'h8000_0013, 1'b0, 2'd0, 1'b0, 64'd0);
    collect(lat, w0, a0, m0, d0, a1, m1, d1);
    chk("bp_lat", 64'(lat), 64'd2);
    chk("bp_rdata", resp_rdata, 64'h0000_0000_0000_0055);
    held = resp_rdata;
    req_addr = 64'h8000_0016; req_wen = 1'b0; req_size = 2'd1; req_signed = 1'b1;
    req_wdata = 64'd0; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_rdata_stable", resp_rdata, 64'h0000_0000_0000_0055);
      chk("bp_err_stable", {63'd0, resp_err}, 64'd0);
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
    end
    release_resp();
    @(negedge clk);
    chk("bp_req_ready_after", {63'd0, req_ready}, 64'd1);
    chk("bp_resp_valid_after", {63'd0, resp_valid}, 64'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    collect(lat, w0, a0, m0, d0, a1, m1, d1);
    chk("bp2_lat", 64'(lat), 64'd2);
    chk("bp2_addr0", a0, 64'h8000_0010);
    chk("bp2_rdata", resp_rdata, 64'h0000_0000_0000_1122);
    release_resp();

    // Boundary-crossing load refused when splitting is disabled.
    @(negedge clk);
    req_addr = 64'h8000_0007; req_wen = 1'b0; req_size = 2'd1; req_signed = 1'b1;
    req_valid_nm = 1'b1;
    chk("nm_req_ready", {63'd0, req_ready_nm}, 64'd1);
    @(posedge clk);
    #1 req_valid_nm = 1'b0;
    @(negedge clk);
    chk("nm_dmem_en", {63'd0, dmem_en_nm}, 64'd0);
    chk("nm_resp_valid", {63'd0, resp_valid_nm}, 64'd1);
    chk("nm_resp_err", {63'd0, resp_err_nm}, 64'd1);
    chk("nm_resp_rdata", resp_rdata_nm, 64'd0);
    resp_ready_nm = 1'b1;
    @(posedge clk);
    #1 resp_ready_nm = 1'b0;
    @(negedge clk);
    req_addr = 64'h8000_0000; req_size = 2'd0; req_signed = 1'b0;
    req_valid_nm = 1'b1;
    chk("nm2_req_ready", {63'd0, req_ready_nm}, 64'd1);
    @(posedge clk);
    #1 req_valid_nm = 1'b0;
    @(negedge clk);
    chk("nm2_dmem_en", {63'd0, dmem_en_nm}, 64'd1);
    @(negedge clk);
    chk("nm2_resp_valid", {63'd0, resp_valid_nm}, 64'd1);
    chk("nm2_resp_err", {63'd0, resp_err_nm}, 64'd0);
    chk("nm2_resp_rdata", resp_rdata_nm, 64'h0000_0000_0000_00A5);
    resp_ready_nm = 1'b1;
    @(posedge clk);
    #1 resp_ready_nm = 1'b0;

    // Async reset during BEAT1 of a split store.
    offer(64'h8000_0026, 1'b1, 2'd2, 1'b0, 64'h0000_0000_5566_7788);
    @(negedge clk);
    chk("ar_beat0_mask", dmem_wmask, 64'hFFFF_0000_0000_0000);
    @(posedge clk);
    #1;
    chk("ar_beat1_en", {63'd0, dmem_en}, 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("ar_dmem_en", {63'd0, dmem_en}, 64'd0);
    chk("ar_dmem_wen", {63'd0, dmem_wen}, 64'd0);
    chk("ar_dmem_wmask", dmem_wmask, 64'd0);
    chk("ar_req_ready", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_mem4_beat0_kept", mem[4], 64'h7788_0000_0000_0000);
    chk("ar_mem5_untouched", mem[5], 64'hDEAD_BEEF_DEAD_BEEF);
    for (int c = 0; c < 3; c++) begin
      chk("ar_req_ready_after", {63'd0, req_ready}, 64'd1);
      chk("ar_no_resp", {63'd0, resp_valid}, 64'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
